id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register. Captures the 12 gated decode control bits and the ID-stage operand and data fields each cycle, and presents them to the EX stage.
- Supports hold for load-use stalls and bubble insertion for branch/jump flushes.
- Keeps saturating bubble and stall counters for debug and performance readout.
- Sits directly downstream of the ID-stage control flush gating.

---
 rtl/id_ex_pipe_reg.sv | 85 ++++++++
 tb/tb_id_ex_pipe_reg.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hold, flush bubbles
// and saturating bubble/stall counters for performance readout.
module id_ex_pipe_reg #(
    parameter int DATA_W  = 23,
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               valid_id,
    input  logic [11:0]        ctrl_id,
    input  logic [DATA_W-1:0]  pc_id,
    input  logic [DATA_W-1:0]  rs_data_id,
    input  logic [DATA_W-1:0]  rt_data_id,
    input  logic [DATA_W-1:0]  imm_id,
    input  logic [RADDR_W-1:0] rs_id,
    input  logic [RADDR_W-1:0] rt_id,
    input  logic [RADDR_W-1:0] rd_id,
    output logic               valid_ex,
    output logic [11:0]        ctrl_ex,
    output logic [DATA_W-1:0]  pc_ex,
    output logic [DATA_W-1:0]  rs_data_ex,
    output logic [DATA_W-1:0]  rt_data_ex,
    output logic [DATA_W-1:0]  imm_ex,
    output logic [RADDR_W-1:0] rs_ex,
    output logic [RADDR_W-1:0] rt_ex,
    output logic [RADDR_W-1:0] rd_ex,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic bubbleInc;
    logic stallInc;
    logic doLoad;

    // Classify this edge: flush beats stall, stall beats load.
    always_comb begin
        doLoad    = !flush && !stall;
        stallInc  = !flush && stall;
        bubbleInc = flush || (doLoad && !valid_id);
    end

    // Pipeline contents: clear on reset/flush, hold on stall, else load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_ex   <= 1'b0;
            ctrl_ex    <= '0;
            pc_ex      <= '0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            rd_ex      <= '0;
        end else if (doLoad) begin
            valid_ex   <= valid_id;
            ctrl_ex    <= valid_id ? ctrl_id : 12'h000;
            pc_ex      <= pc_id;
            rs_data_ex <= rs_data_id;
            rt_data_ex <= rt_data_id;
            imm_ex     <= imm_id;
            rs_ex      <= rs_id;
            rt_ex      <= rt_id;
            rd_ex      <= rd_id;
        end
    end

    // Saturating event counters; at most one step per edge each.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (bubbleInc && bubble_cnt != CntMax)
                bubble_cnt <= bubble_cnt + 1'b1;
            if (stallInc && stall_cnt != CntMax)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: default instance plus a
// CNT_W=4 instance sharing the same stimulus for saturation.
module tb_id_ex_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_id;
    logic [11:0] ctrl_id;
    logic [22:0] pc_id, rs_data_id, rt_data_id, imm_id;
    logic [4:0]  rs_id, rt_id, rd_id;

    logic        valid_ex, valid_ex4;
    logic [11:0] ctrl_ex, ctrl_ex4;
    logic [22:0] pc_ex, rs_data_ex, rt_data_ex, imm_ex;
    logic [22:0] pc_ex4, rs_data_ex4, rt_data_ex4, imm_ex4;
    logic [4:0]  rs_ex, rt_ex, rd_ex, rs_ex4, rt_ex4, rd_ex4;
    logic [15:0] bubble_cnt, stall_cnt;
    logic [3:0]  bubble_cnt4, stall_cnt4;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_id(valid_id), .ctrl_id(ctrl_id), .pc_id(pc_id),
        .rs_data_id(rs_data_id), .rt_data_id(rt_data_id),
        .imm_id(imm_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .valid_ex(valid_ex), .ctrl_ex(ctrl_ex), .pc_ex(pc_ex),
        .rs_data_ex(rs_data_ex), .rt_data_ex(rt_data_ex),
        .imm_ex(imm_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
        .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
    );

    id_ex_pipe_reg #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_id(valid_id), .ctrl_id(ctrl_id), .pc_id(pc_id),
        .rs_data_id(rs_data_id), .rt_data_id(rt_data_id),
        .imm_id(imm_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .valid_ex(valid_ex4), .ctrl_ex(ctrl_ex4), .pc_ex(pc_ex4),
        .rs_data_ex(rs_data_ex4), .rt_data_ex(rt_data_ex4),
        .imm_ex(imm_ex4), .rs_ex(rs_ex4), .rt_ex(rt_ex4), .rd_ex(rd_ex4),
        .bubble_cnt(bubble_cnt4), .stall_cnt(stall_cnt4)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randInputs();
        valid_id   = 1'($urandom);
        ctrl_id    = 12'($urandom);
        pc_id      = 23'($urandom);
        rs_data_id = 23'($urandom);
        rt_data_id = 23'($urandom);
        imm_id     = 23'($urandom);
        rs_id      = 5'($urandom);
        rt_id      = 5'($urandom);
        rd_id      = 5'($urandom);
        stall      = 1'($urandom);
        flush      = 1'($urandom);
    endtask

    task automatic checkCleared(input string tag);
        checkVal({tag, ".valid"}, 32'(valid_ex), 0);
        checkVal({tag, ".ctrl"}, 32'(ctrl_ex), 0);
        checkVal({tag, ".pc"}, 32'(pc_ex), 0);
        checkVal({tag, ".rsd"}, 32'(rs_data_ex), 0);
        checkVal({tag, ".rtd"}, 32'(rt_data_ex), 0);
        checkVal({tag, ".imm"}, 32'(imm_ex), 0);
        checkVal({tag, ".rs"}, 32'(rs_ex), 0);
        checkVal({tag, ".rt"}, 32'(rt_ex), 0);
        checkVal({tag, ".rd"}, 32'(rd_ex), 0);
    endtask

    initial begin
        // Reset held two cycles under random inputs
        rst = 1'b1;
        randInputs();
        step();
        randInputs();
        step();
        checkCleared("reset");
        checkVal("reset.bub", 32'(bubble_cnt), 0);
        checkVal("reset.stl", 32'(stall_cnt), 0);
        checkVal("reset.bub4", 32'(bubble_cnt4), 0);

        // Plain load
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        valid_id = 1'b1; ctrl_id = 12'hA55; pc_id = 23'h000010;
        rs_data_id = 23'h000123; rt_data_id = 23'h000456;
        imm_id = 23'h7FFFFF; rs_id = 5'd3; rt_id = 5'd4; rd_id = 5'd9;
        step();
        checkVal("load.valid", 32'(valid_ex), 1);
        checkVal("load.ctrl", 32'(ctrl_ex), 32'hA55);
        checkVal("load.pc", 32'(pc_ex), 32'h10);
        checkVal("load.rsd", 32'(rs_data_ex), 32'h123);
        checkVal("load.rtd", 32'(rt_data_ex), 32'h456);
        checkVal("load.imm", 32'(imm_ex), 32'h7FFFFF);
        checkVal("load.rs", 32'(rs_ex), 3);
        checkVal("load.rt", 32'(rt_ex), 4);
        checkVal("load.rd", 32'(rd_ex), 9);
        checkVal("load.bub", 32'(bubble_cnt), 0);
        checkVal("load.stl", 32'(stall_cnt), 0);

        // Stall hold over three cycles
        ctrl_id = 12'h0F0; pc_id = 23'h000020; rd_id = 5'd7;
        step();
        checkVal("pre.ctrl", 32'(ctrl_ex), 32'h0F0);
        stall = 1'b1;
        ctrl_id = 12'h123; pc_id = 23'h000030; rd_id = 5'd11;
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("hold.ctrl", 32'(ctrl_ex), 32'h0F0);
            checkVal("hold.pc", 32'(pc_ex), 32'h20);
            checkVal("hold.rd", 32'(rd_ex), 7);
        end
        checkVal("hold.stl", 32'(stall_cnt), 3);
        checkVal("hold.bub", 32'(bubble_cnt), 0);
        stall = 1'b0;
        step();
        checkVal("resume.ctrl", 32'(ctrl_ex), 32'h123);
        checkVal("resume.pc", 32'(pc_ex), 32'h30);
        checkVal("resume.rd", 32'(rd_ex), 11);
        checkVal("resume.stl", 32'(stall_cnt), 3);

        // Flush while stalled
        stall = 1'b1; flush = 1'b1;
        step();
        checkCleared("flush");
        checkVal("flush.bub", 32'(bubble_cnt), 1);
        checkVal("flush.stl", 32'(stall_cnt), 3);

        // Invalid ID slot
        stall = 1'b0; flush = 1'b0;
        valid_id = 1'b0; ctrl_id = 12'hFFF; pc_id = 23'h000040;
        step();
        checkVal("inval.valid", 32'(valid_ex), 0);
        checkVal("inval.ctrl", 32'(ctrl_ex), 0);
        checkVal("inval.pc", 32'(pc_ex), 32'h40);
        checkVal("inval.bub", 32'(bubble_cnt), 2);

        // Saturation on the 4-bit instance
        flush = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checkVal("sat.bub4", 32'(bubble_cnt4), 15);
        checkVal("sat.bub", 32'(bubble_cnt), 22);
        checkVal("sat.stl4", 32'(stall_cnt4), 3);
        flush = 1'b0; stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checkVal("sat.stl4", 32'(stall_cnt4), 15);
        checkVal("sat.stl", 32'(stall_cnt), 23);
        checkVal("sat.bub4b", 32'(bubble_cnt4), 15);

        // Reset mid-stall/flush clears counters
        rst = 1'b1; flush = 1'b1;
        step();
        checkVal("rst.bub4", 32'(bubble_cnt4), 0);
        checkVal("rst.stl4", 32'(stall_cnt4), 0);
        checkVal("rst.bub", 32'(bubble_cnt), 0);
        checkVal("rst.stl", 32'(stall_cnt), 0);
        rst = 1'b0; flush = 1'b0;
        step();
        checkVal("post.stl", 32'(stall_cnt), 1);
        checkVal("post.bub", 32'(bubble_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCompared, nMismatched);
        $finish;
    end

endmodule
